// File: rtl/compare_unit_if.sv
// Operand/result handshake bundle for compare_unit.
// slave: the comparator side; master: the producer/consumer side.
interface compare_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] first_data;
  logic [WIDTH-1:0] second_data;
  logic [2:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic             is_equal;
  logic             is_less;

  modport slave (
    input  in_valid,
    input  first_data,
    input  second_data,
    input  mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output is_equal,
    output is_less
  );

  modport master (
    output in_valid,
    output first_data,
    output second_data,
    output mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  is_equal,
    input  is_less
  );
endinterface

// File: rtl/compare_unit.sv
// Two-stage pipelined operand comparator with valid/ready ports and a
// saturating counter of delivered true results.
module compare_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  compare_unit_if.slave        bus,
  input  logic                 clear_count,
  output logic [CNT_WIDTH-1:0] match_count
);

  localparam logic [2:0] ModeEq  = 3'b000;
  localparam logic [2:0] ModeNe  = 3'b001;
  localparam logic [2:0] ModeLtu = 3'b010;
  localparam logic [2:0] ModeGeu = 3'b011;
  localparam logic [2:0] ModeLt  = 3'b100;
  localparam logic [2:0] ModeGe  = 3'b101;

  // Stage A: captured operands
  logic             a_valid_q, a_valid_d;
  logic [WIDTH-1:0] a_first_q, a_first_d;
  logic [WIDTH-1:0] a_second_q, a_second_d;
  logic [2:0]       a_mode_q, a_mode_d;

  // Stage B: registered result beat
  logic out_valid_q, out_valid_d;
  logic result_q, result_d;
  logic is_equal_q, is_equal_d;
  logic is_less_q, is_less_d;

  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic b_ready;
  logic in_ready;
  logic eq_c, ltu_c, lts_c, less_c, result_c;
  logic count_inc;

  // Relation evaluation on the stage A registers
  always_comb begin
    eq_c   = (a_first_q == a_second_q);
    ltu_c  = (a_first_q < a_second_q);
    lts_c  = ($signed(a_first_q) < $signed(a_second_q));
    less_c = a_mode_q[2] ? lts_c : ltu_c;
    unique case (a_mode_q)
      ModeEq:  result_c = eq_c;
      ModeNe:  result_c = ~eq_c;
      ModeLtu: result_c = ltu_c;
      ModeGeu: result_c = ~ltu_c;
      ModeLt:  result_c = lts_c;
      ModeGe:  result_c = ~lts_c;
      default: result_c = 1'b0;
    endcase
  end

  // A stage may load whenever the stage downstream of it can take its beat
  always_comb begin
    b_ready  = ~out_valid_q | bus.out_ready;
    in_ready = ~a_valid_q | b_ready;

    a_valid_d  = a_valid_q;
    a_first_d  = a_first_q;
    a_second_d = a_second_q;
    a_mode_d   = a_mode_q;
    if (in_ready) begin
      a_valid_d  = bus.in_valid;
      a_first_d  = bus.first_data;
      a_second_d = bus.second_data;
      a_mode_d   = bus.mode;
    end

    out_valid_d = out_valid_q;
    result_d    = result_q;
    is_equal_d  = is_equal_q;
    is_less_d   = is_less_q;
    if (b_ready) begin
      out_valid_d = a_valid_q;
      result_d    = result_c;
      is_equal_d  = eq_c;
      is_less_d   = less_c;
    end
  end

  // Saturating tally of delivered true results; clear wins over increment
  always_comb begin
    count_inc = out_valid_q & bus.out_ready & result_q;
    count_d   = count_q;
    if (clear_count) begin
      count_d = '0;
    end else if (count_inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid_q   <= 1'b0;
      a_first_q   <= '0;
      a_second_q  <= '0;
      a_mode_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= 1'b0;
      is_equal_q  <= 1'b0;
      is_less_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_first_q   <= a_first_d;
      a_second_q  <= a_second_d;
      a_mode_q    <= a_mode_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      is_equal_q  <= is_equal_d;
      is_less_q   <= is_less_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.is_equal  = is_equal_q;
  assign bus.is_less   = is_less_q;
  assign match_count   = count_q;

endmodule

// File: tb/tb_compare_unit.sv
// Scoreboard bench for compare_unit: an 8-bit/2-bit-counter instance for
// protocol, sweep and saturation, and a 32-bit instance for wide compares.
module tb_compare_unit;
  localparam int unsigned WA = 8;
  localparam int unsigned CA = 2;
  localparam int unsigned WB = 32;
  localparam int unsigned CB = 8;

  typedef struct packed {
    logic        res;
    logic        eq;
    logic        lt;
    int unsigned t;
    logic        chk;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic clr_a, clr_b;
  logic [CA-1:0] cnt_a;
  logic [CB-1:0] cnt_b;

  always #5 clk = ~clk;

  compare_unit_if #(.WIDTH(WA)) bus_a ();
  compare_unit_if #(.WIDTH(WB)) bus_b ();

  compare_unit #(.WIDTH(WA), .CNT_WIDTH(CA)) u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_a),
    .clear_count (clr_a),
    .match_count (cnt_a)
  );

  compare_unit #(.WIDTH(WB), .CNT_WIDTH(CB)) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_b),
    .clear_count (clr_b),
    .match_count (cnt_b)
  );

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned acc_a = 0;
  logic        chk_lat = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference relation: {result, is_equal, is_less} for a w-bit compare
  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] m, input int w);
    logic eq, ltu, lts, lt, res;
    eq  = (a == b);
    ltu = (a < b);
    if (a[w-1] != b[w-1]) lts = a[w-1];
    else                  lts = ltu;
    lt = m[2] ? lts : ltu;
    case (m)
      3'd0:    res = eq;
      3'd1:    res = !eq;
      3'd2:    res = ltu;
      3'd3:    res = !ltu;
      3'd4:    res = lts;
      3'd5:    res = !lts;
      default: res = 1'b0;
    endcase
    return {res, eq, lt};
  endfunction

  // Monitor A: scoreboard, hold stability, counter model
  initial begin
    exp_t          e;
    logic [2:0]    m3;
    logic          hold_v = 1'b0;
    logic [2:0]    hold_val = '0;
    logic [CA-1:0] mdl = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        q_a.delete();
        mdl    = '0;
        hold_v = 1'b0;
      end else begin
        check_val("count_a", cnt_a, mdl);
        if (hold_v) begin
          check_val("hold_valid", bus_a.out_valid, 1);
          check_val("hold_beat", {bus_a.result, bus_a.is_equal, bus_a.is_less}, hold_val);
        end
        hold_v   = bus_a.out_valid && !bus_a.out_ready;
        hold_val = {bus_a.result, bus_a.is_equal, bus_a.is_less};
        if (bus_a.out_valid && bus_a.out_ready) begin
          if (q_a.size() == 0) begin
            check_val("spurious_a", bus_a.out_valid, 0);
          end else begin
            e = q_a.pop_front();
            check_val("result_a", bus_a.result, e.res);
            check_val("equal_a", bus_a.is_equal, e.eq);
            check_val("less_a", bus_a.is_less, e.lt);
            if (e.chk) check_val("latency_a", cyc - e.t, 2);
            if (e.res && mdl != {CA{1'b1}}) mdl = mdl + 1'b1;
          end
        end
        if (clr_a) mdl = '0;
        if (bus_a.in_valid && bus_a.in_ready) begin
          m3 = model(32'(bus_a.first_data), 32'(bus_a.second_data), bus_a.mode, WA);
          e  = '{res: m3[2], eq: m3[1], lt: m3[0], t: cyc, chk: chk_lat};
          q_a.push_back(e);
          acc_a++;
        end
      end
    end
  end

  // Monitor B: wide-operand scoreboard and counter model
  initial begin
    exp_t          e;
    logic [2:0]    m3;
    logic [CB-1:0] mdl = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q_b.delete();
        mdl = '0;
      end else begin
        check_val("count_b", cnt_b, mdl);
        if (bus_b.out_valid && bus_b.out_ready) begin
          if (q_b.size() == 0) begin
            check_val("spurious_b", bus_b.out_valid, 0);
          end else begin
            e = q_b.pop_front();
            check_val("result_b", bus_b.result, e.res);
            check_val("equal_b", bus_b.is_equal, e.eq);
            check_val("less_b", bus_b.is_less, e.lt);
            if (e.res && mdl != {CB{1'b1}}) mdl = mdl + 1'b1;
          end
        end
        if (clr_b) mdl = '0;
        if (bus_b.in_valid && bus_b.in_ready) begin
          m3 = model(bus_b.first_data, bus_b.second_data, bus_b.mode, WB);
          e  = '{res: m3[2], eq: m3[1], lt: m3[0], t: cyc, chk: 1'b0};
          q_b.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m);
    logic ok = 1'b0;
    bus_a.in_valid    = 1'b1;
    bus_a.first_data  = a;
    bus_a.second_data = b;
    bus_a.mode        = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = bus_a.in_ready;
      step();
      if (ok) break;
    end
    if (!ok) check_val("accept_timeout_a", ok, 1);
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
    logic ok = 1'b0;
    bus_b.in_valid    = 1'b1;
    bus_b.first_data  = a;
    bus_b.second_data = b;
    bus_b.mode        = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = bus_b.in_ready;
      step();
      if (ok) break;
    end
    if (!ok) check_val("accept_timeout_b", ok, 1);
    bus_b.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (q_a.size() == 0 && q_b.size() == 0) break;
    end
    check_val("drain_a", q_a.size(), 0);
    check_val("drain_b", q_b.size(), 0);
    step();
  endtask

  task automatic pulse_clear_a();
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
  endtask

  logic [7:0] bp_a[4] = '{8'h10, 8'h30, 8'h20, 8'hF0};
  logic [7:0] bp_b[4] = '{8'h20, 8'h20, 8'h10, 8'h01};

  initial begin
    int   idx;
    int   acc0;
    logic ok;
    reset = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.first_data = '0; bus_a.second_data = '0; bus_a.mode = '0;
    bus_b.in_valid = 1'b0; bus_b.first_data = '0; bus_b.second_data = '0; bus_b.mode = '0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    step();
    step();

    check_val("rst_in_ready", bus_a.in_ready, 1);
    check_val("rst_out_valid", bus_a.out_valid, 0);
    check_val("rst_result", bus_a.result, 0);
    check_val("rst_equal", bus_a.is_equal, 0);
    check_val("rst_less", bus_a.is_less, 0);
    check_val("rst_count", cnt_a, 0);
    check_val("rst_in_ready_b", bus_b.in_ready, 1);
    reset = 1'b0;
    step();

    // Mode sweep, back to back: 0x80 vs 0x01 across all modes
    chk_lat = 1'b1;
    for (int m = 0; m < 8; m++) send_a(8'h80, 8'h01, 3'(m));
    chk_lat = 1'b0;
    drain();

    // Equality with all-ones operands
    pulse_clear_a();
    send_a(8'hFF, 8'hFF, 3'b000);
    drain();
    check_val("eq_count", cnt_a, 1);

    // Backpressure: 5 cycles of out_ready=0 while streaming 4 beats
    bus_a.out_ready = 1'b0;
    acc0 = int'(acc_a);
    idx  = 0;
    for (int c = 0; c < 5; c++) begin
      bus_a.in_valid    = 1'b1;
      bus_a.first_data  = bp_a[idx];
      bus_a.second_data = bp_b[idx];
      bus_a.mode        = 3'b010;
      @(negedge clk);
      ok = bus_a.in_ready;
      step();
      if (ok) idx++;
    end
    check_val("bp_accepted", int'(acc_a) - acc0, 2);
    check_val("bp_in_ready", bus_a.in_ready, 0);
    check_val("bp_out_valid", bus_a.out_valid, 1);
    bus_a.out_ready = 1'b1;
    for (int i = idx; i < 4; i++) send_a(bp_a[i], bp_b[i], 3'b010);
    drain();

    // Saturation of the 2-bit counter
    pulse_clear_a();
    for (int i = 0; i < 5; i++) send_a(8'h5A, 8'h5A, 3'b000);
    drain();
    check_val("sat_count", cnt_a, 3);

    // Clear coinciding with a true handshake
    pulse_clear_a();
    send_a(8'h01, 8'h01, 3'b000);
    step();
    check_val("clr_beat_valid", bus_a.out_valid, 1);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check_val("clr_priority", cnt_a, 0);
    drain();

    // Wide operands
    send_b(32'h7FFF_FFFF, 32'h8000_0000, 3'b010);
    send_b(32'h7FFF_FFFF, 32'h8000_0000, 3'b100);
    send_b(32'h7FFF_FFFF, 32'h8000_0000, 3'b101);
    send_b(32'h8000_0000, 32'h8000_0000, 3'b000);
    drain();
    check_val("wide_count", cnt_b, 3);

    // Reset mid-stream with both stages full
    send_a(8'h02, 8'h02, 3'b000);
    drain();
    bus_a.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus_a.in_valid    = 1'b1;
      bus_a.first_data  = 8'h07;
      bus_a.second_data = 8'h07;
      bus_a.mode        = 3'b000;
      step();
    end
    reset = 1'b1;
    bus_a.in_valid = 1'b0;
    #1;
    check_val("mid_rst_out_valid", bus_a.out_valid, 0);
    check_val("mid_rst_count", cnt_a, 0);
    check_val("mid_rst_in_ready", bus_a.in_ready, 1);
    step();
    step();
    reset = 1'b0;
    bus_a.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_val("stale_out", bus_a.out_valid, 0);
    end
    step();
    check_val("end_queue_a", q_a.size(), 0);
    check_val("end_queue_b", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
